ru_fault_allocator: RTL and testbench

//   Upstream of data_buffer in the recompute-unit BISR path. Accepts faulty-PE

---
 rtl/ru_fault_allocator_pkg.sv | 19 +
 rtl/ru_fault_allocator_cam_match.sv | 31 +++
 rtl/ru_fault_allocator.sv | 123 ++++++++++++
 tb/tb_ru_fault_allocator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ru_fault_allocator_pkg.sv
// Shared types and width helpers for the recompute-unit fault allocator.
// Holds the allocator state enum and clog2-based width functions.
package ru_fault_allocator_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOCKED  = 2'd1,
    FAIL    = 2'd2
  } alloc_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ru_fault_allocator_cam_match.sv
// ru_cam_match: N-entry parallel (row,col) comparator.
// Ports: key_row/key_col, entry_row/entry_col/en in; hit, idx (lowest match) out.
module ru_cam_match #(
  parameter int N     = 4,
  parameter int RW    = 4,
  parameter int CW    = 4,
  parameter int IDX_W = 2
) (
  input  logic [RW-1:0]         key_row,
  input  logic [CW-1:0]         key_col,
  input  logic [N-1:0][RW-1:0]  entry_row,
  input  logic [N-1:0][CW-1:0]  entry_col,
  input  logic [N-1:0]          en,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (en[i] && entry_row[i] == key_row &&
          entry_col[i] == key_col) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ru_fault_allocator.sv
// ru_fault_allocator: dedupes BIST fault reports and binds them to RU slots.
// Ports: fault_* handshake in, ru_row/ru_col/ru_en table out, status, lookup.
module ru_fault_allocator
  import ru_fault_allocator_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  parameter int IDX_W  = idx_width(NUM_RU),
  parameter int CNT_W  = cnt_width(NUM_RU)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          fault_valid,
  output logic                          fault_ready,
  input  logic [ROWS-1:0]               fault_row,
  input  logic [COLS-1:0]               fault_col,
  input  logic                          bist_done,
  output logic [NUM_RU-1:0][ROWS-1:0]   ru_row,
  output logic [NUM_RU-1:0][COLS-1:0]   ru_col,
  output logic [NUM_RU-1:0]             ru_en,
  output logic [CNT_W-1:0]              num_faults,
  output logic                          repair_ok,
  output logic                          repair_fail,
  output logic                          coord_err,
  input  logic [ROWS-1:0]               lookup_row,
  input  logic [COLS-1:0]               lookup_col,
  output logic                          lookup_hit,
  output logic [IDX_W-1:0]              lookup_idx
);

  alloc_state_t state, state_nxt;

  logic             accept;
  logic             bad;
  logic             dup_hit;
  logic [IDX_W-1:0] dup_idx;
  logic             dup;
  logic             full;
  logic             store;
  logic             overflow;
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;

  ru_cam_match #(
    .N(NUM_RU), .RW(ROWS), .CW(COLS), .IDX_W(IDX_W)
  ) u_dedupe (
    .key_row(fault_row), .key_col(fault_col),
    .entry_row(ru_row), .entry_col(ru_col), .en(ru_en),
    .hit(dup_hit), .idx(dup_idx)
  );

  ru_cam_match #(
    .N(NUM_RU), .RW(ROWS), .CW(COLS), .IDX_W(IDX_W)
  ) u_lookup (
    .key_row(lookup_row), .key_col(lookup_col),
    .entry_row(ru_row), .entry_col(ru_col), .en(ru_en),
    .hit(lk_hit), .idx(lk_idx)
  );

  assign accept   = fault_valid & fault_ready;
  assign bad      = (fault_row >= ROWS'(ROWS)) |
                    (fault_col >= COLS'(COLS));
  assign dup      = dup_hit & ru_en[dup_idx];
  assign full     = (num_faults == CNT_W'(NUM_RU));
  assign store    = accept & ~bad & ~dup & ~full;
  assign overflow = accept & ~bad & ~dup & full;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Overflow beats bist_done; a stored entry is already in the table.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (clear)          state_nxt = COLLECT;
        else if (overflow)  state_nxt = FAIL;
        else if (bist_done) state_nxt = LOCKED;
      end
      LOCKED, FAIL: begin
        if (clear) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    fault_ready = (state == COLLECT) & rst_n & ~clear;
    repair_ok   = (state == LOCKED);
    repair_fail = (state == FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ru_row     <= '0;
      ru_col     <= '0;
      ru_en      <= '0;
      num_faults <= '0;
      coord_err  <= 1'b0;
      lookup_hit <= 1'b0;
      lookup_idx <= '0;
    end else begin
      if (accept && bad) coord_err <= 1'b1;
      if (store) begin
        for (int i = 0; i < NUM_RU; i++) begin
          if (num_faults == CNT_W'(i)) begin
            ru_row[i] <= fault_row;
            ru_col[i] <= fault_col;
            ru_en[i]  <= 1'b1;
          end
        end
        num_faults <= num_faults + CNT_W'(1);
      end
      lookup_hit <= lk_hit;
      lookup_idx <= lk_idx;
    end
  end

endmodule

// File: tb/tb_ru_fault_allocator.sv
// Bench for ru_fault_allocator: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_ru_fault_allocator;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NRU  = 4;

  logic clk = 1'b0;
  logic rst_n, clear, fault_valid, bist_done;
  logic fault_ready;
  logic [ROWS-1:0] fault_row, lookup_row;
  logic [COLS-1:0] fault_col, lookup_col;
  logic [NRU-1:0][ROWS-1:0] ru_row;
  logic [NRU-1:0][COLS-1:0] ru_col;
  logic [NRU-1:0] ru_en;
  logic [2:0] num_faults;
  logic repair_ok, repair_fail, coord_err, lookup_hit;
  logic [1:0] lookup_idx;

  ru_fault_allocator #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NRU)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .fault_valid(fault_valid), .fault_ready(fault_ready),
    .fault_row(fault_row), .fault_col(fault_col),
    .bist_done(bist_done),
    .ru_row(ru_row), .ru_col(ru_col), .ru_en(ru_en),
    .num_faults(num_faults),
    .repair_ok(repair_ok), .repair_fail(repair_fail),
    .coord_err(coord_err),
    .lookup_row(lookup_row), .lookup_col(lookup_col),
    .lookup_hit(lookup_hit), .lookup_idx(lookup_idx)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: state 0=collect 1=locked 2=fail, table as queues.
  int mr[$];
  int mc[$];
  int ms = 0;
  bit merr = 0, mlh = 0, chk_en = 0;
  int mli = 0;

  always @(posedge clk) begin
    bit lh, found, ovf;
    int li;
    lh = 0; li = 0; found = 0; ovf = 0;
    for (int i = 0; i < mr.size(); i++) begin
      if (!lh && mr[i] == int'(lookup_row) && mc[i] == int'(lookup_col)) begin
        lh = 1; li = i;
      end
      if (mr[i] == int'(fault_row) && mc[i] == int'(fault_col)) found = 1;
    end
    if (!rst_n || clear) begin
      mr.delete(); mc.delete();
      ms = 0; merr = 0; mlh = 0; mli = 0;
    end else begin
      mlh = lh; mli = li;
      if (fault_valid && ms == 0) begin
        if (int'(fault_row) >= ROWS || int'(fault_col) >= COLS) merr = 1;
        else if (!found) begin
          if (mr.size() < NRU) begin
            mr.push_back(int'(fault_row));
            mc.push_back(int'(fault_col));
          end else ovf = 1;
        end
      end
      if (ms == 0) begin
        if (ovf) ms = 2;
        else if (bist_done) ms = 1;
      end
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", 32'(fault_ready),
          32'(ms == 0 && rst_n && !clear));
      chk("m_ok", 32'(repair_ok), 32'(ms == 1));
      chk("m_fail", 32'(repair_fail), 32'(ms == 2));
      chk("m_num", 32'(num_faults), 32'(mr.size()));
      chk("m_en", 32'(ru_en), 32'((1 << mr.size()) - 1));
      chk("m_err", 32'(coord_err), 32'(merr));
      chk("m_lhit", 32'(lookup_hit), 32'(mlh));
      chk("m_lidx", 32'(lookup_idx), 32'(mli));
      for (int i = 0; i < NRU; i++) begin
        chk("m_row", 32'(ru_row[i]), 32'(i < mr.size() ? mr[i] : 0));
        chk("m_col", 32'(ru_col[i]), 32'(i < mc.size() ? mc[i] : 0));
      end
    end
  end

  task automatic drive(input logic v, input int r, input int c,
                       input logic d, input logic cl,
                       input int lr, input int lc);
    fault_valid = v;
    fault_row   = ROWS'(r);
    fault_col   = COLS'(c);
    bist_done   = d;
    clear       = cl;
    lookup_row  = ROWS'(lr);
    lookup_col  = COLS'(lc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rep(input int r, input int c);
    drive(1, r, c, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    fault_valid = 0; fault_row = '0; fault_col = '0;
    bist_done = 0; clear = 0; lookup_row = '0; lookup_col = '0;
    idle();
    idle();
    chk("rst_ready", 32'(fault_ready), 32'd0);
    chk("rst_en", 32'(ru_en), 32'd0);
    chk("rst_ok", 32'(repair_ok), 32'd0);
    rst_n = 1'b1;
    idle();

    // Two faults then done.
    rep(1, 2);
    rep(3, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("s1_en", 32'(ru_en), 32'b0011);
    chk("s1_r0", 32'(ru_row[0]), 32'd1);
    chk("s1_c0", 32'(ru_col[0]), 32'd2);
    chk("s1_r1", 32'(ru_row[1]), 32'd3);
    chk("s1_c1", 32'(ru_col[1]), 32'd0);
    chk("s1_num", 32'(num_faults), 32'd2);
    chk("s1_ok", 32'(repair_ok), 32'd1);
    drive(0, 0, 0, 0, 0, 3, 0);
    chk("s1_lhit", 32'(lookup_hit), 32'd1);
    chk("s1_lidx", 32'(lookup_idx), 32'd1);

    // Duplicates, then lookup of slot 2.
    drive(0, 0, 0, 0, 1, 0, 0);
    rep(2, 2);
    rep(2, 2);
    rep(2, 2);
    chk("dup_num", 32'(num_faults), 32'd1);
    chk("dup_en", 32'(ru_en), 32'b0001);
    rep(0, 1);
    rep(0, 3);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3);
    chk("lk_hit", 32'(lookup_hit), 32'd1);
    chk("lk_idx", 32'(lookup_idx), 32'd2);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("lk_miss", 32'(lookup_hit), 32'd0);
    chk("lk_midx", 32'(lookup_idx), 32'd0);

    // Overflow.
    drive(0, 0, 0, 0, 1, 0, 0);
    rep(0, 0);
    rep(1, 1);
    rep(2, 2);
    rep(3, 3);
    rep(1, 0);
    chk("ov_fail", 32'(repair_fail), 32'd1);
    chk("ov_ready", 32'(fault_ready), 32'd0);
    chk("ov_num", 32'(num_faults), 32'd4);
    chk("ov_r3", 32'(ru_row[3]), 32'd3);
    chk("ov_c0", 32'(ru_col[0]), 32'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("clr_fail", 32'(repair_fail), 32'd0);
    chk("clr_en", 32'(ru_en), 32'd0);
    chk("clr_num", 32'(num_faults), 32'd0);

    // Fault and done in the same cycle.
    rep(1, 1);
    drive(1, 3, 3, 1, 0, 0, 0);
    chk("sim_ok", 32'(repair_ok), 32'd1);
    chk("sim_num", 32'(num_faults), 32'd2);
    chk("sim_r1", 32'(ru_row[1]), 32'd3);

    // Out-of-range coordinates.
    drive(0, 0, 0, 0, 1, 0, 0);
    rep(2, 1);
    rep(5, 0);
    chk("ce_err", 32'(coord_err), 32'd1);
    chk("ce_num", 32'(num_faults), 32'd1);
    rep(0, 7);
    chk("ce_en", 32'(ru_en), 32'b0001);

    // Reset mid-collect.
    rst_n = 1'b0;
    idle();
    chk("mr_err", 32'(coord_err), 32'd0);
    chk("mr_num", 32'(num_faults), 32'd0);
    chk("mr_en", 32'(ru_en), 32'd0);
    rst_n = 1'b1;

    // No faults then done.
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("z_ok", 32'(repair_ok), 32'd1);
    chk("z_en", 32'(ru_en), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("z_lhit", 32'(lookup_hit), 32'd0);

    idle();
    idle();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
